// File: rtl/dcm_clkgen_prog_interface_if.sv
// Register-side request/status and DCM_CLKGEN PROGEN/PROGDATA/PROGDONE signals
// for the DCM_CLKGEN programming sequencer.
interface dcm_clkgen_prog_interface_if;
  logic [7:0] mul_i;
  logic [7:0] div_i;
  logic       load_i;
  logic [7:0] mul_o;
  logic [7:0] div_o;
  logic       busy_o;
  logic       done_o;
  logic       error_o;
  logic       dcm_progen_o;
  logic       dcm_progdata_o;
  logic       dcm_progdone_i;

  modport master (
    output mul_i, div_i, load_i, dcm_progdone_i,
    input  mul_o, div_o, busy_o, done_o, error_o, dcm_progen_o, dcm_progdata_o
  );

  modport slave (
    input  mul_i, div_i, load_i, dcm_progdone_i,
    output mul_o, div_o, busy_o, done_o, error_o, dcm_progen_o, dcm_progdata_o
  );
endinterface

// File: rtl/dcm_clkgen_prog_interface.sv
// Runs the DCM_CLKGEN LoadD / LoadM / Go serial sequence on PROGEN/PROGDATA,
// waits for PROGDONE and reports the programmed M-1/D-1 back.
module dcm_clkgen_prog_interface #(
  parameter logic [7:0]  DEFAULT_MUL    = 8'd1,
  parameter logic [7:0]  DEFAULT_DIV    = 8'd1,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  dcm_clkgen_prog_interface_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, LOADD, GAP1, LOADM, GAP2, GO, WAITDONE
  } state_t;

  state_t      state;
  logic [7:0]  mul_sh;
  logic [7:0]  div_sh;
  logic [9:0]  shift_q;
  logic [3:0]  bit_cnt;
  logic [15:0] wait_cnt;
  logic [7:0]  mul_q;
  logic [7:0]  div_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;
  logic        progen_q;
  logic        progdata_q;

  logic [9:0] frame_d;
  logic [9:0] frame_m;

  // Command frames are sent LSB first: LoadD = 1,0,D[0..7]; LoadM = 1,1,M[0..7].
  assign frame_d = {bus.div_i, 2'b01};
  assign frame_m = {mul_sh, 2'b11};

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state      <= IDLE;
      mul_sh     <= DEFAULT_MUL;
      div_sh     <= DEFAULT_DIV;
      shift_q    <= '0;
      bit_cnt    <= '0;
      wait_cnt   <= '0;
      mul_q      <= DEFAULT_MUL;
      div_q      <= DEFAULT_DIV;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      progen_q   <= 1'b0;
      progdata_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          progen_q   <= 1'b0;
          progdata_q <= 1'b0;
          busy_q     <= 1'b0;
          // busy_q still high here only in the done cycle; a load then is ignored.
          if (bus.load_i && !busy_q) begin
            mul_sh <= bus.mul_i;
            div_sh <= bus.div_i;
            if (bus.mul_i == 8'd0) begin
              error_q <= 1'b1;
            end else begin
              error_q    <= 1'b0;
              busy_q     <= 1'b1;
              state      <= LOADD;
              progen_q   <= 1'b1;
              progdata_q <= frame_d[0];
              shift_q    <= frame_d >> 1;
              bit_cnt    <= '0;
            end
          end
        end

        LOADD: begin
          if (bit_cnt == 4'd9) begin
            state      <= GAP1;
            progen_q   <= 1'b0;
            progdata_q <= 1'b0;
          end else begin
            progdata_q <= shift_q[0];
            shift_q    <= shift_q >> 1;
            bit_cnt    <= bit_cnt + 4'd1;
          end
        end

        GAP1: begin
          state      <= LOADM;
          progen_q   <= 1'b1;
          progdata_q <= frame_m[0];
          shift_q    <= frame_m >> 1;
          bit_cnt    <= '0;
        end

        LOADM: begin
          if (bit_cnt == 4'd9) begin
            state      <= GAP2;
            progen_q   <= 1'b0;
            progdata_q <= 1'b0;
          end else begin
            progdata_q <= shift_q[0];
            shift_q    <= shift_q >> 1;
            bit_cnt    <= bit_cnt + 4'd1;
          end
        end

        GAP2: begin
          state      <= GO;
          progen_q   <= 1'b1;
          progdata_q <= 1'b0;
        end

        GO: begin
          state      <= WAITDONE;
          progen_q   <= 1'b0;
          progdata_q <= 1'b0;
          wait_cnt   <= '0;
        end

        WAITDONE: begin
          // PROGDONE is ignored in the first WAITDONE cycle (wait_cnt == 0).
          if (bus.dcm_progdone_i && wait_cnt != 16'd0) begin
            mul_q  <= mul_sh;
            div_q  <= div_sh;
            done_q <= 1'b1;
            state  <= IDLE;
          end else if (wait_cnt == TIMEOUT_CYCLES - 16'd1) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        default: begin
          state      <= IDLE;
          busy_q     <= 1'b0;
          progen_q   <= 1'b0;
          progdata_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mul_o          = mul_q;
  assign bus.div_o          = div_q;
  assign bus.busy_o         = busy_q;
  assign bus.done_o         = done_q;
  assign bus.error_o        = error_q;
  assign bus.dcm_progen_o   = progen_q;
  assign bus.dcm_progdata_o = progdata_q;

endmodule

// File: tb/tb_dcm_clkgen_prog_interface.sv
// Directed bench for the DCM_CLKGEN programming sequencer (TIMEOUT_CYCLES=100).
module tb_dcm_clkgen_prog_interface;

  logic clk;
  logic reset_n;
  int unsigned n_cmp;
  int unsigned n_bad;

  dcm_clkgen_prog_interface_if bus();

  dcm_clkgen_prog_interface #(
    .DEFAULT_MUL    (8'd1),
    .DEFAULT_DIV    (8'd1),
    .TIMEOUT_CYCLES (16'd100)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1 (first cycle after the edge sampling load_i).
  task automatic issue_load(input logic [7:0] m, input logic [7:0] d);
    bus.mul_i  = m;
    bus.div_i  = d;
    bus.load_i = 1'b1;
    tick();
    bus.load_i = 1'b0;
  endtask

  task automatic wait_done(input int unsigned max_cycles);
    int unsigned n;
    n = 0;
    while (!bus.done_o && n < max_cycles) begin
      tick();
      n++;
    end
    check_eq("done_seen", 32'(bus.done_o), 32'd1);
  endtask

  initial begin
    logic [1:23] exp_en;
    logic [1:23] exp_dat;
    int unsigned done_cnt;
    int unsigned en_cnt;

    n_cmp = 0;
    n_bad = 0;
    reset_n            = 1'b0;
    bus.mul_i          = 8'h00;
    bus.div_i          = 8'h00;
    bus.load_i         = 1'b0;
    bus.dcm_progdone_i = 1'b0;

    // Reset
    repeat (3) tick();
    check_eq("rst_mul",    32'(bus.mul_o), 32'd1);
    check_eq("rst_div",    32'(bus.div_o), 32'd1);
    check_eq("rst_progen", 32'(bus.dcm_progen_o), 32'd0);
    check_eq("rst_pdata",  32'(bus.dcm_progdata_o), 32'd0);
    check_eq("rst_busy",   32'(bus.busy_o), 32'd0);
    check_eq("rst_done",   32'(bus.done_o), 32'd0);
    check_eq("rst_error",  32'(bus.error_o), 32'd0);
    reset_n = 1'b1;
    tick();

    // Program M-1=3, D-1=1; PROGDONE after 20 WAITDONE cycles
    exp_en  = 23'b1111111111_0_1111111111_0_1;
    exp_dat = 23'b1010000000_0_1111000000_0_0;
    issue_load(8'h03, 8'h01);
    for (int c = 1; c <= 23; c++) begin
      check_eq($sformatf("seq_en_c%0d", c),  32'(bus.dcm_progen_o),   32'(exp_en[c]));
      check_eq($sformatf("seq_dat_c%0d", c), 32'(bus.dcm_progdata_o), 32'(exp_dat[c]));
      check_eq($sformatf("seq_busy_c%0d", c), 32'(bus.busy_o), 32'd1);
      tick();
    end
    check_eq("wait_en",   32'(bus.dcm_progen_o), 32'd0);
    check_eq("wait_busy", 32'(bus.busy_o), 32'd1);
    repeat (20) tick();
    bus.dcm_progdone_i = 1'b1;
    wait_done(10);
    check_eq("p1_mul",  32'(bus.mul_o), 32'h03);
    check_eq("p1_div",  32'(bus.div_o), 32'h01);
    check_eq("p1_busy_at_done", 32'(bus.busy_o), 32'd1);
    bus.dcm_progdone_i = 1'b0;
    tick();
    check_eq("p1_done_pulse", 32'(bus.done_o), 32'd0);
    check_eq("p1_idle_busy",  32'(bus.busy_o), 32'd0);

    // Illegal request
    issue_load(8'h00, 8'h05);
    check_eq("ill_error", 32'(bus.error_o), 32'd1);
    check_eq("ill_busy",  32'(bus.busy_o), 32'd0);
    en_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.dcm_progen_o) en_cnt++;
      tick();
    end
    check_eq("ill_no_progen", en_cnt, 32'd0);
    check_eq("ill_error_sticky", 32'(bus.error_o), 32'd1);
    check_eq("ill_mul", 32'(bus.mul_o), 32'h03);
    check_eq("ill_div", 32'(bus.div_o), 32'h01);

    // Legal load clears error; minimum latency with PROGDONE already high
    issue_load(8'h10, 8'h02);
    check_eq("clr_error", 32'(bus.error_o), 32'd0);
    check_eq("clr_busy",  32'(bus.busy_o), 32'd1);
    repeat (23) tick();
    bus.dcm_progdone_i = 1'b1;
    check_eq("lat_c24_done", 32'(bus.done_o), 32'd0);
    tick();
    check_eq("lat_c25_done", 32'(bus.done_o), 32'd0);
    tick();
    check_eq("lat_c26_done", 32'(bus.done_o), 32'd1);
    check_eq("lat_mul", 32'(bus.mul_o), 32'h10);
    check_eq("lat_div", 32'(bus.div_o), 32'h02);
    bus.dcm_progdone_i = 1'b0;
    tick();

    // Second load during LOADM is ignored
    issue_load(8'h20, 8'h04);
    repeat (13) tick();
    check_eq("ign_in_loadm", 32'(bus.dcm_progen_o), 32'd1);
    bus.mul_i  = 8'h55;
    bus.div_i  = 8'h66;
    bus.load_i = 1'b1;
    tick();
    bus.load_i = 1'b0;
    bus.mul_i  = 8'h77;
    bus.dcm_progdone_i = 1'b1;
    wait_done(40);
    check_eq("ign_mul", 32'(bus.mul_o), 32'h20);
    check_eq("ign_div", 32'(bus.div_o), 32'h04);
    bus.dcm_progdone_i = 1'b0;
    tick();

    // Timeout with PROGDONE held low
    issue_load(8'h07, 8'h03);
    repeat (23) tick();
    done_cnt = 0;
    for (int c = 0; c < 99; c++) begin
      if (bus.done_o) done_cnt++;
      tick();
    end
    check_eq("to_before_err",  32'(bus.error_o), 32'd0);
    check_eq("to_before_busy", 32'(bus.busy_o), 32'd1);
    tick();
    check_eq("to_error", 32'(bus.error_o), 32'd1);
    check_eq("to_busy",  32'(bus.busy_o), 32'd0);
    check_eq("to_no_done", done_cnt + 32'(bus.done_o), 32'd0);
    check_eq("to_mul", 32'(bus.mul_o), 32'h20);
    check_eq("to_div", 32'(bus.div_o), 32'h04);

    // Reset in the 5th LOADD cycle
    issue_load(8'h09, 8'h08);
    repeat (4) tick();
    check_eq("mr_in_loadd", 32'(bus.dcm_progen_o), 32'd1);
    reset_n = 1'b0;
    tick();
    check_eq("mr_progen", 32'(bus.dcm_progen_o), 32'd0);
    check_eq("mr_pdata",  32'(bus.dcm_progdata_o), 32'd0);
    check_eq("mr_busy",   32'(bus.busy_o), 32'd0);
    check_eq("mr_error",  32'(bus.error_o), 32'd0);
    check_eq("mr_mul",    32'(bus.mul_o), 32'd1);
    check_eq("mr_div",    32'(bus.div_o), 32'd1);
    reset_n = 1'b1;
    tick();
    check_eq("mr_idle_progen", 32'(bus.dcm_progen_o), 32'd0);
    issue_load(8'h0A, 8'h00);
    check_eq("mr_reload_busy", 32'(bus.busy_o), 32'd1);
    repeat (23) tick();
    bus.dcm_progdone_i = 1'b1;
    wait_done(10);
    check_eq("mr_new_mul", 32'(bus.mul_o), 32'h0A);
    check_eq("mr_new_div", 32'(bus.div_o), 32'h00);
    bus.dcm_progdone_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
